// File: rtl/riscv_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Package : riscv_pkg -- shared fetch-stage constants, state and PC-select types
// Rev     : 1.0
// ----------------------------------------------------------------------------
package riscv_pkg;

    localparam logic [31:0] c_nop      = 32'h0000_0013;
    localparam logic [31:0] c_reset_pc = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_WAIT    = 3'd2,
        ST_OUT     = 3'd3,
        ST_DISCARD = 3'd4
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_HOLD     = 2'd0,
        PC_INC      = 2'd1,
        PC_REDIRECT = 2'd2
    } pc_sel_t;

    // Instructions are word aligned; the low two address bits carry no meaning.
    function automatic logic [31:0] align_word(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_unit_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Interface : instruction_fetch_unit_if -- req/gnt/rvalid instruction-memory bus
// Rev       : 1.0
// ----------------------------------------------------------------------------
interface instruction_fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );

endinterface
`default_nettype wire

// File: rtl/program_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : program_counter -- PC register with hold / +4 / redirect next-PC mux
// Rev    : 1.0
// ----------------------------------------------------------------------------
module program_counter
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_reset_pc
)(
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  pc_sel_t     i_sel,
    input  logic [31:0] i_target,
    output logic [31:0] o_pc
);

    logic [31:0] r_pc;
    logic [31:0] w_pc_next;

    // Increment wraps naturally at 2^32.
    always_comb begin
        w_pc_next = r_pc;
        unique case (i_sel)
            PC_INC:      w_pc_next = r_pc + 32'd4;
            PC_REDIRECT: w_pc_next = i_target;
            default:     w_pc_next = r_pc;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign o_pc = r_pc;

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : instruction_fetch_unit -- single-outstanding fetch FSM feeding IF/ID
// Rev    : 1.0
// ----------------------------------------------------------------------------
module instruction_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_reset_pc
)(
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic                       i_stall,
    input  logic                       i_redirect,
    input  logic [31:0]                i_redirect_pc,
    instruction_fetch_unit_if.master   imem,
    output logic [31:0]                o_pc,
    output logic [31:0]                o_instruction,
    output logic                       o_valid
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    pc_sel_t      w_pc_sel;
    logic         w_capture;
    logic         w_flush;
    logic [31:0]  w_pc;
    logic [31:0]  w_target;

    logic [31:0]  r_pc_out;
    logic [31:0]  r_instr;
    logic         r_valid;

    assign w_target = align_word(i_redirect_pc);

    program_counter #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_sel     (w_pc_sel),
        .i_target  (w_target),
        .o_pc      (w_pc)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Redirect is checked first in every state so it outranks stall and rvalid.
    always_comb begin
        w_state_next = r_state;
        w_pc_sel     = PC_HOLD;
        w_capture    = 1'b0;
        w_flush      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_state_next = ST_REQ;
            end
            ST_REQ: begin
                if (i_redirect) begin
                    w_pc_sel     = PC_REDIRECT;
                    w_state_next = imem.imem_gnt ? ST_DISCARD : ST_REQ;
                end else if (imem.imem_gnt) begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i_redirect) begin
                    w_pc_sel     = PC_REDIRECT;
                    w_state_next = imem.imem_rvalid ? ST_REQ : ST_DISCARD;
                end else if (imem.imem_rvalid) begin
                    w_capture    = 1'b1;
                    w_pc_sel     = PC_INC;
                    w_state_next = ST_OUT;
                end
            end
            ST_OUT: begin
                if (i_redirect) begin
                    w_flush      = 1'b1;
                    w_pc_sel     = PC_REDIRECT;
                    w_state_next = ST_REQ;
                end else if (!i_stall) begin
                    w_flush      = 1'b1;
                    w_state_next = ST_REQ;
                end
            end
            ST_DISCARD: begin
                // A redirect retargets the PC; the squashed response still
                // closes the outstanding request, so rvalid always leaves.
                if (i_redirect) begin
                    w_pc_sel = PC_REDIRECT;
                end
                if (imem.imem_rvalid) begin
                    w_state_next = ST_REQ;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_pc_out <= 32'h0000_0000;
            r_instr  <= c_nop;
            r_valid  <= 1'b0;
        end else if (w_capture) begin
            r_pc_out <= w_pc;
            r_instr  <= imem.imem_rdata;
            r_valid  <= 1'b1;
        end else if (w_flush) begin
            r_valid  <= 1'b0;
        end
    end

    assign imem.imem_req  = (r_state == ST_REQ);
    assign imem.imem_addr = w_pc;

    assign o_pc          = r_pc_out;
    assign o_instruction = r_instr;
    assign o_valid       = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tb_instruction_fetch_unit -- directed self-checking fetch-unit bench
// Rev    : 1.0
// ----------------------------------------------------------------------------
module tb_instruction_fetch_unit;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] o_pc;
    logic [31:0] o_instruction;
    logic        o_valid;

    int n_checks = 0;
    int n_errors = 0;

    instruction_fetch_unit_if imem_if ();

    instruction_fetch_unit dut (
        .i_clk         (clk),
        .i_reset_n     (reset_n),
        .i_stall       (stall),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .imem          (imem_if.master),
        .o_pc          (o_pc),
        .o_instruction (o_instruction),
        .o_valid       (o_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered with the FSM in REQ; gnt and rvalid each answer in one cycle.
    task automatic do_fetch(input logic [31:0] exp_pc, input logic [31:0] data);
        check("fetch_req", 32'(imem_if.imem_req), 32'd1);
        check("fetch_addr", imem_if.imem_addr, exp_pc);
        imem_if.imem_gnt = 1'b1;
        step();
        imem_if.imem_gnt = 1'b0;
        check("wait_req", 32'(imem_if.imem_req), 32'd0);
        imem_if.imem_rvalid = 1'b1;
        imem_if.imem_rdata  = data;
        step();
        imem_if.imem_rvalid = 1'b0;
        check("out_valid", 32'(o_valid), 32'd1);
        check("out_pc", o_pc, exp_pc);
        check("out_instr", o_instruction, data);
        check("out_req", 32'(imem_if.imem_req), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n             = 1'b0;
        stall               = 1'b0;
        redirect            = 1'b0;
        redirect_pc         = 32'h0;
        imem_if.imem_gnt    = 1'b0;
        imem_if.imem_rvalid = 1'b0;
        imem_if.imem_rdata  = 32'h0;
        repeat (2) step();

        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_pc", o_pc, 32'h0);
        check("rst_instr", o_instruction, 32'h0000_0013);
        check("rst_req", 32'(imem_if.imem_req), 32'd0);
        check("rst_addr", imem_if.imem_addr, 32'h0);

        // Release: IDLE for one edge, then REQ.
        reset_n = 1'b1;
        check("idle_req", 32'(imem_if.imem_req), 32'd0);
        step();
        do_fetch(32'h0, 32'h0050_0093);
        step();
        check("next_valid", 32'(o_valid), 32'd0);
        do_fetch(32'h4, 32'h0010_0113);
        step();
        do_fetch(32'h8, 32'h0020_8193);

        // Stall holds the presented instruction.
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_valid", 32'(o_valid), 32'd1);
            check("stall_pc", o_pc, 32'h8);
            check("stall_instr", o_instruction, 32'h0020_8193);
            check("stall_req", 32'(imem_if.imem_req), 32'd0);
        end
        stall = 1'b0;
        step();
        check("unstall_req", 32'(imem_if.imem_req), 32'd1);
        check("unstall_addr", imem_if.imem_addr, 32'hC);
        check("unstall_valid", 32'(o_valid), 32'd0);

        // Redirect one cycle after gnt squashes the in-flight word.
        imem_if.imem_gnt = 1'b1;
        step();
        imem_if.imem_gnt = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        step();
        redirect = 1'b0;
        check("discard_req", 32'(imem_if.imem_req), 32'd0);
        step();
        imem_if.imem_rvalid = 1'b1;
        imem_if.imem_rdata  = 32'hDEAD_BEEF;
        step();
        imem_if.imem_rvalid = 1'b0;
        check("squash_valid", 32'(o_valid), 32'd0);
        check("squash_instr", o_instruction, 32'h0020_8193);
        check("squash_pc", o_pc, 32'h8);
        check("redir_addr", imem_if.imem_addr, 32'h100);

        // Redirect while stalled in OUT flushes and re-requests at once.
        do_fetch(32'h100, 32'h00A0_0513);
        stall = 1'b1;
        step();
        check("out_hold_valid", 32'(o_valid), 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        step();
        redirect = 1'b0;
        stall    = 1'b0;
        check("flush_valid", 32'(o_valid), 32'd0);
        check("flush_req", 32'(imem_if.imem_req), 32'd1);
        check("flush_addr", imem_if.imem_addr, 32'h200);
        check("flush_pc", o_pc, 32'h100);
        check("flush_instr", o_instruction, 32'h00A0_0513);

        // Redirect in REQ without gnt retargets the pending request.
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        do_fetch(32'hFFFF_FFFC, 32'h1234_5678);
        step();
        check("wrap_addr", imem_if.imem_addr, 32'h0);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0203;
        step();
        redirect = 1'b0;
        check("align_addr", imem_if.imem_addr, 32'h200);

        // Redirect coincident with gnt goes through DISCARD.
        imem_if.imem_gnt = 1'b1;
        redirect         = 1'b1;
        redirect_pc      = 32'h0000_0040;
        step();
        imem_if.imem_gnt = 1'b0;
        redirect         = 1'b0;
        check("gntredir_req", 32'(imem_if.imem_req), 32'd0);
        imem_if.imem_rvalid = 1'b1;
        imem_if.imem_rdata  = 32'hDEAD_BEEF;
        step();
        imem_if.imem_rvalid = 1'b0;
        check("gntredir_addr", imem_if.imem_addr, 32'h40);
        check("gntredir_valid", 32'(o_valid), 32'd0);
        check("gntredir_instr", o_instruction, 32'h1234_5678);

        // Reset during WAIT, then a stale rvalid after release.
        imem_if.imem_gnt = 1'b1;
        step();
        imem_if.imem_gnt = 1'b0;
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(o_valid), 32'd0);
        check("mid_rst_req", 32'(imem_if.imem_req), 32'd0);
        check("mid_rst_instr", o_instruction, 32'h0000_0013);
        check("mid_rst_addr", imem_if.imem_addr, 32'h0);
        step();
        reset_n             = 1'b1;
        imem_if.imem_rvalid = 1'b1;
        imem_if.imem_rdata  = 32'hDEAD_BEEF;
        step();
        check("stale_valid0", 32'(o_valid), 32'd0);
        check("stale_req", 32'(imem_if.imem_req), 32'd1);
        step();
        imem_if.imem_rvalid = 1'b0;
        check("stale_valid1", 32'(o_valid), 32'd0);
        check("stale_instr", o_instruction, 32'h0000_0013);
        do_fetch(32'h0, 32'h0050_0093);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
